// File: rtl/xy_route_unit.sv
// xy_route_unit: registered route-compute stage for a 2D mesh router.
// Each accepted header is routed in XY or YX order, or flagged as out-of-mesh.
// The result is queued in a small FIFO together with the destination.
// Per-port and error pop counters are kept alongside the queue.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// valid is never withdrawn while the transfer is still pending.
// in_ready depends only on the occupancy count, never on out_ready.
module xy_route_unit #(
  parameter int COORD_W = 30,
  parameter int MESH_X  = 16,
  parameter int MESH_Y  = 16,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COORD_W-1:0]   cur_x,
  input  logic [COORD_W-1:0]   cur_y,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [COORD_W-1:0]   in_dest_x,
  input  logic [COORD_W-1:0]   in_dest_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_port,
  output logic [4:0]           out_port_oh,
  output logic                 out_err,
  output logic [COORD_W-1:0]   out_dest_x,
  output logic [COORD_W-1:0]   out_dest_y,
  input  logic                 clr_cnt,
  output logic [5*CNT_W-1:0]   port_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [COORD_W-1:0] LIM_X = COORD_W'(MESH_X);
  localparam logic [COORD_W-1:0] LIM_Y = COORD_W'(MESH_Y);
  localparam logic [AW:0]        FULL  = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0]   CMAX  = {CNT_W{1'b1}};

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_EAST  = 3'd1;
  localparam logic [2:0] P_WEST  = 3'd2;
  localparam logic [2:0] P_NORTH = 3'd3;
  localparam logic [2:0] P_SOUTH = 3'd4;

  logic [2:0]         w_port;
  logic               w_err;
  logic               w_push;
  logic               w_pop;

  logic [2:0]         r_mem_port [DEPTH];
  logic               r_mem_err  [DEPTH];
  logic [COORD_W-1:0] r_mem_dx   [DEPTH];
  logic [COORD_W-1:0] r_mem_dy   [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic [CNT_W-1:0]   r_pcnt [5];
  logic [CNT_W-1:0]   r_ecnt;

  // Route the incoming header; an out-of-mesh destination is sent local and flagged.
  always_comb begin
    w_err  = (in_dest_x >= LIM_X) || (in_dest_y >= LIM_Y);
    w_port = P_LOCAL;
    if (w_err) begin
      w_port = P_LOCAL;
    end else if (!mode) begin
      if      (in_dest_x > cur_x) w_port = P_EAST;
      else if (in_dest_x < cur_x) w_port = P_WEST;
      else if (in_dest_y > cur_y) w_port = P_NORTH;
      else if (in_dest_y < cur_y) w_port = P_SOUTH;
    end else begin
      if      (in_dest_y > cur_y) w_port = P_NORTH;
      else if (in_dest_y < cur_y) w_port = P_SOUTH;
      else if (in_dest_x > cur_x) w_port = P_EAST;
      else if (in_dest_x < cur_x) w_port = P_WEST;
    end
  end

  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // Entry storage: no reset needed, because reads are qualified by out_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_port[r_wr_ptr] <= w_port;
      r_mem_err[r_wr_ptr]  <= w_err;
      r_mem_dx[r_wr_ptr]   <= in_dest_x;
      r_mem_dy[r_wr_ptr]   <= in_dest_y;
    end
  end

  // Pointers wrap naturally; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  assign out_port    = r_mem_port[r_rd_ptr];
  assign out_err     = r_mem_err[r_rd_ptr];
  assign out_dest_x  = r_mem_dx[r_rd_ptr];
  assign out_dest_y  = r_mem_dy[r_rd_ptr];
  assign out_port_oh = 5'b00001 << out_port;

  // Saturating pop statistics; a clear takes priority over a coincident pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 5; p++) r_pcnt[p] <= '0;
      r_ecnt <= '0;
    end else if (clr_cnt) begin
      for (int p = 0; p < 5; p++) r_pcnt[p] <= '0;
      r_ecnt <= '0;
    end else if (w_pop) begin
      for (int p = 0; p < 5; p++) begin
        if (out_port == 3'(p) && r_pcnt[p] != CMAX) r_pcnt[p] <= r_pcnt[p] + 1'b1;
      end
      if (out_err && r_ecnt != CMAX) r_ecnt <= r_ecnt + 1'b1;
    end
  end

  for (genvar g = 0; g < 5; g++) begin : g_cnt
    assign port_cnt[g*CNT_W +: CNT_W] = r_pcnt[g];
  end
  assign err_cnt = r_ecnt;

endmodule

// File: doc/xy_route_unit.md
# xy_route_unit

Parametrised, registered successor to the combinational `top` route-compute block (`dest_x`/`dest_y` → `outport`). It computes the output port for each incoming header from a configurable destination and local coordinate, with selectable XY or YX dimension order and out-of-mesh error detection. Results are buffered in a small header FIFO with valid/ready on both sides. It sits between a router input buffer and the switch allocator. Per-port statistics counters are included.

## Interface
- `COORD_W`, 30: width of each coordinate field.
- `MESH_X`, 16: mesh size in X. Legal `dest_x` is 0..MESH_X-1.
- `MESH_Y`, 16: mesh size in Y. Legal `dest_y` is 0..MESH_Y-1.
- `DEPTH`, 4: FIFO entries. Must be a power of 2 and ≥2.
- `CNT_W`, 16: width of each statistics counter.

Ports:
- `clk` input 1: the single clock. All logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset. Release is synchronised externally.
- `cur_x`, `cur_y` input COORD_W each: local router coordinate. Quasi-static.
- `mode` input 1: dimension order. 0 = XY, 1 = YX. Sampled at accept.
- `in_valid` input 1: header valid.
- `in_ready` output 1: FIFO can accept a header.
- `in_dest_x`, `in_dest_y` input COORD_W each: destination coordinate, unsigned.
- `out_valid` output 1: head FIFO entry valid.
- `out_ready` input 1: consumer accepts the head entry.
- `out_port` output 3: encoded port. 0 local, 1 east, 2 west, 3 north, 4 south.
- `out_port_oh` output 5: one-hot form of `out_port`. Bit n corresponds to code n.
- `out_err` output 1: head entry had an out-of-mesh destination.
- `out_dest_x`, `out_dest_y` output COORD_W each: destination passed through with the entry.
- `clr_cnt` input 1: synchronous clear of all counters.
- `port_cnt` output 5*CNT_W: per-port pop counters. Slice n belongs to port code n.
- `err_cnt` output CNT_W: count of popped entries with `out_err` set.

## Operation
- Accept occurs when `in_valid && in_ready`. The route is computed combinationally from the input fields, `cur_x`, `cur_y` and `mode`. It is then written to the FIFO as {port, err, dest_x, dest_y}.
- Error check: if `in_dest_x >= MESH_X` or `in_dest_y >= MESH_Y`, then err=1 and port=0 (local, for ejection and discard).
- XY order (mode=0), applied in sequence:
  - dest_x > cur_x → east.
  - dest_x < cur_x → west.
  - otherwise dest_y > cur_y → north.
  - dest_y < cur_y → south.
  - otherwise local.
- YX order (mode=1): the Y comparison is made first, then the X comparison, then local.
- All comparisons are unsigned at full COORD_W.
- FIFO:
  - Circular buffer with rd/wr pointers of log2(DEPTH) bits that wrap naturally.
  - Occupancy count is log2(DEPTH)+1 bits.
  - `in_ready` = (count != DEPTH). It is registered-equivalent and does not depend on `out_ready`.
  - `out_valid` = (count != 0).
  - Output fields are driven from the entry at the read pointer.
- Full with a pop in the same cycle: `in_ready` is 0, so there is no push. Count decrements.
- Empty with a push: there is no bypass. The entry becomes visible the next cycle.
- Push and pop in the same cycle (neither full nor empty): count is unchanged and both pointers advance.
- Counters:
  - On each pop (`out_valid && out_ready`), `port_cnt[out_port]` increments.
  - If `out_err` is set on that pop, `err_cnt` also increments.
  - Counters saturate at 2^CNT_W-1.
  - If `clr_cnt` coincides with a pop, the clear wins and the counter becomes 0.
- Reset: count=0, pointers=0, all counters=0.
  - Outputs after reset: `in_ready`=1, `out_valid`=0.
  - `out_port`, `out_err`, `out_dest_*` and `out_port_oh` reflect stale storage and are don't-care while `out_valid`=0. The bench must not check them.
  - Reset mid-operation discards all entries immediately (asynchronous).

## Timing
- Accept to `out_valid`: 1 cycle when the FIFO is empty.
- Sustained throughput: 1 header per cycle while `out_ready`=1.
- Head entry and `out_valid` are stable while `out_valid && !out_ready`.
- Counters update on the clock edge that completes the pop. They are visible the following cycle.
- `mode`, `cur_x` and `cur_y` only affect headers accepted after they change. Stored entries are never recomputed.

## Test plan
- Basic routing, XY: cur=(5,5), mode=0. Send dests (9,2), (1,7), (5,8), (5,0), (5,5). Required: ports 1, 2, 3, 4, 0, with `out_port_oh` = 00010, 00100, 01000, 10000, 00001.
- YX order: cur=(5,5), mode=1, dest=(9,2). Required: port 4 (south). Then toggle mode to 0 with the entry still queued; the popped entry must remain 4.
- Error detection: dest=(16,3) with MESH_X=16. Required: port 0, `out_err`=1, `err_cnt`=1 and `port_cnt[0]`=1 after the pop.
- Backpressure: hold `out_ready`=0 and push 5 headers with DEPTH=4. Required: `in_ready`=0 after the 4th accept and the 5th is held. Then set `out_ready`=1 for 1 cycle. Required: `in_ready`=1 the next cycle and FIFO order is preserved. Run ≥3 pointer wraps with random push/pop against a reference queue.
- Counters: with CNT_W=4, pop 20 east entries. Required: `port_cnt[1]`=15 (saturated). Assert `clr_cnt` on a pop cycle. Required: counter reads 0 next cycle.
- Reset: with 3 entries queued, pulse `rst_n` low asynchronously between edges. Required: `out_valid`=0 and `in_ready`=1 immediately, and all counters read 0.
